bin_count_avs: RTL and testbench

Avalon-MM responder peripheral for the Nios II system: the processor-side bus initiates register accesses, and this block answers them while running a prescaled 8-bit binary counter. The counter value drives LEDR and two seven-segment digits via the `hex5_hex4` bus, which the board top inverts onto HEX4/HEX5. The block also exposes the slider switches for software polling. It sits inside the Qsys system on the 50 MHz system clock domain.

---
 rtl/bin_count_pkg.sv | 26 ++
 rtl/hex7seg_enc.sv | 11 +
 rtl/bin_count_avs.sv | 133 +++++++++++++
 tb/tb_bin_count_avs.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_count_pkg.sv
// Shared constants for the binary-counter Avalon-MM peripheral:
// register map, CTRL bit positions and the seven-segment hex table.
package bin_count_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned SW_W   = 4;
    localparam int unsigned CTRL_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_SWITCH = 2'd3;

    localparam int unsigned CTRL_RUN    = 0;
    localparam int unsigned CTRL_DIR    = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // Active-high gfedcba patterns, entry 0 in the lowest slice.
    localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational nibble to active-high seven-segment encoder.
module hex7seg_enc
    import bin_count_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/bin_count_avs.sv
// Avalon-MM responder running a prescaled 8-bit up/down counter shown on
// LEDR and two hex digits, with wrap interrupt and switch readback.
module bin_count_avs
    import bin_count_pkg::*;
#(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [SW_W-1:0]   sw,
    output logic [15:0]       hex5_hex4,
    output logic [CNT_W-1:0]  ledr,
    output logic              irq
);

    localparam int unsigned PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [15:0] HEX_RST = {1'b0, SEG_LUT[0], 1'b0, SEG_LUT[0]};

    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;
    logic [15:0]       hex_q, hex_d;
    logic [SEG_W-1:0]  seg_lo_c, seg_hi_c;
    logic              tick_c, wrap_set_c;
    logic              unused_c;

    assign unused_c = ^avs_writedata[DATA_W-1:CNT_W];

    // Switch synchronizer; metastability only, so no reset needed.
    always_ff @(posedge CLOCK_50) begin
        sw_meta_q <= sw;
        sw_sync_q <= sw_meta_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            wrap_q   <= 1'b0;
            presc_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
            hex_q    <= HEX_RST;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            presc_q  <= presc_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
            hex_q    <= hex_d;
        end
    end

    // Display is encoded from the next count so it lands with COUNT.
    hex7seg_enc u_enc_lo (.nib_i(count_d[3:0]), .seg_o(seg_lo_c));
    hex7seg_enc u_enc_hi (.nib_i(count_d[7:4]), .seg_o(seg_hi_c));

    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        wrap_d     = wrap_q;
        presc_d    = '0;
        rdata_d    = '0;
        rvalid_d   = avs_read;
        wrap_set_c = 1'b0;
        tick_c     = ctrl_q[CTRL_RUN] && (presc_q == PS_LAST);

        if (ctrl_q[CTRL_RUN] && !tick_c) begin
            presc_d = presc_q + PS_W'(1);
        end

        if (tick_c) begin
            if (ctrl_q[CTRL_DIR]) begin
                count_d    = count_q - CNT_W'(1);
                wrap_set_c = (count_q == '0);
            end else begin
                count_d    = count_q + CNT_W'(1);
                wrap_set_c = (count_q == '1);
            end
        end

        // A CPU write to COUNT overrides the tick and never flags a wrap.
        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL: ctrl_d = avs_writedata[CTRL_W-1:0];
                ADDR_COUNT: begin
                    count_d    = avs_writedata[CNT_W-1:0];
                    wrap_set_c = 1'b0;
                end
                ADDR_STATUS: if (avs_writedata[0]) wrap_d = 1'b0;
                default: ;
            endcase
        end
        if (wrap_set_c) begin
            wrap_d = 1'b1;
        end

        if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
                ADDR_COUNT:  rdata_d = DATA_W'(count_q);
                ADDR_STATUS: rdata_d = DATA_W'(wrap_q);
                default:     rdata_d = DATA_W'(sw_sync_q);
            endcase
        end

        irq_d = wrap_d & ctrl_d[CTRL_IRQ_EN];
        hex_d = {1'b0, seg_hi_c, 1'b0, seg_lo_c};
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign ledr              = count_q;
    assign hex5_hex4         = hex_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_bin_count_avs.sv
// Scoreboard bench for bin_count_avs: directed scenarios then random traffic.
module tb_bin_count_avs;

    localparam int PRESCALE = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [3:0]  sw = 4'h3;
    logic [15:0] hex5_hex4;
    logic [7:0]  ledr;
    logic        irq;

    always #10 CLOCK_50 = ~CLOCK_50;

    bin_count_avs #(.PRESCALE(PRESCALE), .CNT_W(8)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .sw(sw), .hex5_hex4(hex5_hex4), .ledr(ledr), .irq(irq)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    // Reference state: architectural registers plus cycles since last tick.
    int m_ctrl = 0, m_count = 0, m_wrap = 0, m_phase = 0;
    int sw_s1 = 3, sw_s2 = 3;

    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [15:0] disp(int c);
        return {1'b0, lut[(c >> 4) & 15], 1'b0, lut[c & 15]};
    endfunction

    function automatic logic [31:0] regval(int a);
        case (a)
            0:       return 32'(m_ctrl);
            1:       return 32'(m_count);
            2:       return 32'(m_wrap);
            default: return 32'(sw_s2);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic step();
        int nc, ncount, nw, np, raw;
        bit tick, wset;
        nc = m_ctrl; ncount = m_count; nw = m_wrap; np = 0; wset = 0;
        if (reset) begin
            nc = 0; ncount = 0; nw = 0; np = 0;
        end else begin
            if (avs_read) sb.push_back('{cyc + 1, regval(int'(avs_address))});
            tick = ((m_ctrl & 1) != 0) && (m_phase == PRESCALE - 1);
            np = ((m_ctrl & 1) != 0 && !tick) ? m_phase + 1 : 0;
            if (tick) begin
                raw = m_count + (((m_ctrl & 2) != 0) ? -1 : 1);
                wset = (raw < 0) || (raw > 255);
                ncount = (raw + 256) % 256;
            end
            if (avs_write) begin
                case (int'(avs_address))
                    0: nc = int'(avs_writedata & 32'h7);
                    1: begin ncount = int'(avs_writedata & 32'hFF); wset = 0; end
                    2: if (avs_writedata[0]) nw = 0;
                    default: ;
                endcase
            end
            if (wset) nw = 1;
        end
        sw_s2 = sw_s1;
        sw_s1 = int'(sw);
        @(posedge CLOCK_50);
        m_ctrl = nc; m_count = ncount; m_wrap = nw; m_phase = np;
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(int a, int d);
        avs_address = 2'(a); avs_writedata = 32'(d); avs_write = 1'b1;
        step();
        avs_write = 1'b0;
    endtask

    task automatic rd(int a);
        avs_address = 2'(a); avs_read = 1'b1;
        step();
        avs_read = 1'b0;
    endtask

    // Monitor: every cycle compare the response channel and the display outputs.
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            bit exp_valid;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                void'(sb.pop_front());
                n_checks++; n_fail++;
                $display("FAIL rsp_lost: response missing, expected by cycle %0d", cyc - 1);
            end
            exp_valid = (sb.size() > 0) && (sb[0].cyc == cyc);
            check("readdatavalid", 32'(avs_readdatavalid), 32'(exp_valid));
            if (exp_valid) begin
                exp_t e;
                e = sb.pop_front();
                check("readdata", avs_readdata, e.data);
            end else begin
                check("readdata_idle", avs_readdata, 32'h0);
            end
            check("ledr", 32'(ledr), 32'(m_count));
            check("hex5_hex4", 32'(hex5_hex4), 32'(disp(m_count)));
            check("irq", 32'(irq), 32'(m_wrap & ((m_ctrl >> 2) & 1)));
        end
    end

    initial begin
        int guard;
        step();
        mon_en = 1'b1;
        idle(2);
        reset = 1'b0;

        // Reset values and fixed read latency.
        rd(0); rd(1); rd(2); rd(3);
        idle(1);
        check("hex_reset", 32'(hex5_hex4), 32'h3F3F);

        // Up count for 40 cycles.
        wr(0, 1);
        idle(40);
        check("ledr_40cyc", 32'(ledr), 32'h0A);
        check("hex_40cyc", 32'(hex5_hex4), 32'h3F77);
        rd(1);

        // Up wrap with interrupt, then W1C.
        wr(0, 0); wr(1, 8'hFE); wr(0, 5);
        idle(8);
        check("irq_up_wrap", 32'(irq), 32'h1);
        rd(2);
        wr(2, 1);
        check("irq_w1c", 32'(irq), 32'h0);

        // Down wrap.
        wr(0, 0); wr(1, 0); wr(0, 3);
        idle(4);
        check("ledr_down_wrap", 32'(ledr), 32'hFF);
        check("hex_down_wrap", 32'(hex5_hex4), 32'h7171);
        rd(2);

        // COUNT write aligned with a tick.
        wr(0, 1);
        guard = 0;
        while (m_phase != PRESCALE - 1 && guard < 2 * PRESCALE) begin
            step(); guard++;
        end
        check("tick_align_found", 32'(m_phase), 32'(PRESCALE - 1));
        wr(1, 8'h55);
        check("write_beats_tick", 32'(ledr), 32'h55);
        idle(3);
        check("no_early_tick", 32'(ledr), 32'h55);
        idle(1);
        check("next_tick", 32'(ledr), 32'h56);

        // Reset mid-run with switches changed.
        sw = 4'hA;
        idle(2);
        reset = 1'b1;
        avs_address = 2'd1; avs_read = 1'b1;
        step();
        avs_read = 1'b0;
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_hex", 32'(hex5_hex4), 32'h3F3F);
        reset = 1'b0;
        rd(3);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            reset = (r == 0);
            if ($urandom_range(0, 49) == 0) sw = 4'($urandom);
            avs_read = ($urandom_range(0, 99) < 30);
            avs_write = ($urandom_range(0, 99) < 15);
            avs_address = 2'($urandom);
            case (avs_address)
                2'd0:    avs_writedata = {$urandom_range(0, 1) == 0 ? 29'h0 : 29'($urandom), 3'($urandom) | 3'b001};
                2'd1:    avs_writedata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1) * 255) : $urandom;
                default: avs_writedata = $urandom;
            endcase
            step();
            avs_read = 1'b0; avs_write = 1'b0; reset = 1'b0;
        end

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
